// File: rtl/apb3_pkg.sv
// Shared types and constants for the APB3 register responder.
package apb3_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } apb_state_e;

   localparam int unsigned ADDR_LSB = 2;
   localparam int unsigned CNT_W    = 4;

endpackage

// File: rtl/apb3_wait_timer.sv
// Access-phase wait-state counter: load on setup, count down while stalled, flag zero.
module apb3_wait_timer
   import apb3_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/apb3_reg_responder.sv
// APB3 register-file responder with configurable wait states and a read-only ID register.
// Define APB3_RESP_SLVERR_EN to enable pslverr for out-of-range or register-0 writes.
module apb3_reg_responder
   import apb3_pkg::*;
#(
   parameter int unsigned       A_WIDTH     = 32,
   parameter int unsigned       D_WIDTH     = 32,
   parameter int unsigned       NUM_REGS    = 16,
   parameter int unsigned       WAIT_CYCLES = 2,
   parameter logic [D_WIDTH-1:0] ID_VALUE   = 32'h0A9B_0001
)(
   input  logic                         clk,
   input  logic                         prst_n,
   input  logic                         psel,
   input  logic                         penable,
   input  logic                         pwrite,
   input  logic [A_WIDTH-1:0]           paddr,
   input  logic [D_WIDTH-1:0]           pwdata,
   output logic [D_WIDTH-1:0]           prdata,
   output logic                         pready,
   output logic                         pslverr,
   output logic [NUM_REGS*D_WIDTH-1:0]  regs_o
);

   localparam int unsigned IDX_W = A_WIDTH - ADDR_LSB;
   localparam int unsigned CMP_W = (IDX_W > 9) ? IDX_W : 9;

   apb_state_e          state_q;
   logic [IDX_W-1:0]    addr_q;
   logic                write_q;
   logic [D_WIDTH-1:0]  wdata_q;
   logic [D_WIDTH-1:0]  regs_q [1:NUM_REGS-1];

   logic                setup;
   logic                xfer_active;
   logic                cnt_zero;
   logic                complete;
   logic                in_range;
   logic                is_id;
   logic                wr_en;
   logic [D_WIDTH-1:0]  rd_val;
   logic                unused_addr_lsb;

   assign unused_addr_lsb = ^paddr[ADDR_LSB-1:0];

   assign setup       = (state_q == IDLE) && psel && !penable;
   assign xfer_active = (state_q == ACCESS) && psel && penable;
   assign complete    = xfer_active && cnt_zero;
   assign pready      = !((state_q == ACCESS) && !cnt_zero);

   assign in_range = (CMP_W'(addr_q) < CMP_W'(NUM_REGS));
   assign is_id    = (addr_q == '0);
   assign wr_en    = complete && write_q && in_range && !is_id;

   apb3_wait_timer u_wait_timer (
      .clk        (clk),
      .rst_n      (prst_n),
      .load_i     (setup),
      .load_val_i (CNT_W'(WAIT_CYCLES)),
      .dec_i      (xfer_active && !cnt_zero),
      .zero_o     (cnt_zero)
   );

   // Dropping psel in ACCESS abandons the transfer; nothing was committed yet.
   always_ff @(posedge clk or negedge prst_n) begin
      if (!prst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (psel && !penable) begin
                  state_q <= ACCESS;
                  addr_q  <= paddr[A_WIDTH-1:ADDR_LSB];
                  write_q <= pwrite;
                  wdata_q <= pwdata;
               end
            end
            ACCESS: begin
               if (!psel || complete) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge prst_n) begin
      if (!prst_n) begin
         for (int unsigned i = 1; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (wr_en && (addr_q == IDX_W'(i))) begin
               regs_q[i] <= wdata_q;
            end
         end
      end
   end

   always_comb begin
      rd_val = '0;
      if (is_id) begin
         rd_val = ID_VALUE;
      end
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
         if (in_range && (addr_q == IDX_W'(i))) begin
            rd_val = regs_q[i];
         end
      end
   end

   assign prdata = (complete && !write_q) ? rd_val : '0;

`ifdef APB3_RESP_SLVERR_EN
   assign pslverr = complete && (!in_range || (write_q && is_id));
`else
   assign pslverr = 1'b0;
`endif

   assign regs_o[0 +: D_WIDTH] = ID_VALUE;
   for (genvar g = 1; g < NUM_REGS; g++) begin : g_regs_o
      assign regs_o[g*D_WIDTH +: D_WIDTH] = regs_q[g];
   end

endmodule

// File: tb/tb_apb3_reg_responder.sv
// Randomised self-checking bench: two responders (2 wait states and zero wait) against an array model.
module tb_apb3_reg_responder;

   localparam int unsigned NR = 16;
   localparam logic [31:0] ID = 32'h0A9B_0001;

   logic                    clk = 1'b0;
   logic [1:0]              prst_n = 2'b11;
   logic [1:0]              psel = '0;
   logic [1:0]              penable = '0;
   logic [1:0]              pwrite = '0;
   logic [1:0][31:0]        paddr = '0;
   logic [1:0][31:0]        pwdata = '0;
   logic [1:0][31:0]        prdata;
   logic [1:0]              pready;
   logic [1:0]              pslverr;
   logic [1:0][NR*32-1:0]   regs;

   logic [31:0] mregs [2][NR];
   int tests  = 0;
   int failed = 0;

   initial forever #5 clk = ~clk;

   apb3_reg_responder #(
      .A_WIDTH(32), .D_WIDTH(32), .NUM_REGS(NR), .WAIT_CYCLES(2), .ID_VALUE(ID)
   ) u_dut_w2 (
      .clk(clk), .prst_n(prst_n[0]), .psel(psel[0]), .penable(penable[0]),
      .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]),
      .pready(pready[0]), .pslverr(pslverr[0]), .regs_o(regs[0])
   );

   apb3_reg_responder #(
      .A_WIDTH(32), .D_WIDTH(32), .NUM_REGS(NR), .WAIT_CYCLES(0), .ID_VALUE(ID)
   ) u_dut_w0 (
      .clk(clk), .prst_n(prst_n[1]), .psel(psel[1]), .penable(penable[1]),
      .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]),
      .pready(pready[1]), .pslverr(pslverr[1]), .regs_o(regs[1])
   );

   function automatic int wc(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   function automatic logic [31:0] model_read(input int d, input logic [31:0] addr);
      logic [29:0] idx = addr[31:2];
      if (idx == 0) return ID;
      if (idx < NR) return mregs[d][idx];
      return 32'h0;
   endfunction

   function automatic logic model_err(input bit wr, input logic [31:0] addr);
      logic [29:0] idx = addr[31:2];
`ifdef APB3_RESP_SLVERR_EN
      return (idx >= NR) || (wr && idx == 0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic void model_commit(input int d, input bit wr, input logic [31:0] addr,
                                        input logic [31:0] wd);
      logic [29:0] idx = addr[31:2];
      if (wr && idx != 0 && idx < NR) mregs[d][idx] = wd;
   endfunction

   function automatic logic [NR*32-1:0] model_image(input int d);
      logic [NR*32-1:0] img;
      for (int i = 0; i < NR; i++) img[i*32 +: 32] = (i == 0) ? ID : mregs[d][i];
      return img;
   endfunction

   // Drives one transfer; abort_at > 0 drops psel in the wait cycle after that many waits.
   task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                       input int abort_at, output logic [31:0] rd, output logic err,
                       output int waits, output bit done, output logic [31:0] setup_rd);
      rd = '0; err = 1'b0; waits = 0; done = 1'b0;
      psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = wd;
      @(negedge clk);
      setup_rd = prdata[d];
      @(posedge clk); #1;
      penable[d] = 1'b1;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (pready[d]) begin
            rd = prdata[d]; err = pslverr[d]; done = 1'b1;
         end else begin
            waits++;
         end
         if (!done && abort_at != 0 && waits == abort_at) begin
            @(posedge clk); #1;
            psel[d] = 1'b0; penable[d] = 1'b0;
            @(posedge clk); #1;
            return;
         end
         @(posedge clk); #1;
      end
      if (!done) begin
         tests++; failed++;
         $display("FAIL xfer_timeout dut%0d addr=%h: no pready within budget", d, addr);
      end
      psel[d] = 1'b0; penable[d] = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] rd, srd; logic err; int w; bit done;
      #2 prst_n = 2'b00;
      #1;
      for (int d = 0; d < 2; d++) begin
         tests++;
         if (pready[d] !== 1'b1) begin failed++; $display("FAIL rst_pready dut%0d got %b exp 1", d, pready[d]); end
         tests++;
         if (pslverr[d] !== 1'b0) begin failed++; $display("FAIL rst_pslverr dut%0d got %b exp 0", d, pslverr[d]); end
         tests++;
         if (prdata[d] !== 32'h0) begin failed++; $display("FAIL rst_prdata dut%0d got %h exp 0", d, prdata[d]); end
         tests++;
         if (regs[d] !== model_image(d)) begin failed++; $display("FAIL rst_regs dut%0d got %h exp %h", d, regs[d], model_image(d)); end
      end
      repeat (2) @(posedge clk);
      #1 prst_n = 2'b11;
      @(posedge clk); #1;
      xfer(0, 1'b0, 32'h0, 32'h0, 0, rd, err, w, done, srd);
      tests++;
      if (rd !== ID || err !== 1'b0) begin failed++; $display("FAIL rst_read_id got %h/%b exp %h/0", rd, err, ID); end
      xfer(0, 1'b0, 32'h4, 32'h0, 0, rd, err, w, done, srd);
      tests++;
      if (rd !== 32'h0) begin failed++; $display("FAIL rst_read_r1 got %h exp 0", rd); end
   endtask

   task automatic test_wait_states();
      logic [31:0] rd, srd; logic err; int w; bit done;
      xfer(0, 1'b1, 32'h8, 32'hDEADBEEF, 0, rd, err, w, done, srd);
      model_commit(0, 1'b1, 32'h8, 32'hDEADBEEF);
      tests++;
      if (w != 2 || !done) begin failed++; $display("FAIL ws_latency waits %0d exp 2", w); end
      tests++;
      if (regs[0][95:64] !== 32'hDEADBEEF) begin failed++; $display("FAIL ws_regs_o got %h exp deadbeef", regs[0][95:64]); end
      xfer(0, 1'b0, 32'h8, 32'h0, 0, rd, err, w, done, srd);
      tests++;
      if (rd !== 32'hDEADBEEF || srd !== 32'h0) begin
         failed++; $display("FAIL ws_readback got %h (setup %h) exp deadbeef (0)", rd, srd);
      end
   endtask

   task automatic test_zero_wait();
      logic [31:0] rd, srd; logic err; int w1, w2; bit d1, d2;
      xfer(1, 1'b1, 32'hC, 32'h1234, 0, rd, err, w1, d1, srd);
      model_commit(1, 1'b1, 32'hC, 32'h1234);
      xfer(1, 1'b0, 32'hC, 32'h0, 0, rd, err, w2, d2, srd);
      tests++;
      if (w1 != 0 || w2 != 0 || !d1 || !d2) begin failed++; $display("FAIL zw_latency waits %0d/%0d exp 0/0", w1, w2); end
      tests++;
      if (rd !== 32'h1234) begin failed++; $display("FAIL zw_readback got %h exp 1234", rd); end
   endtask

   task automatic test_errors();
      logic [31:0] rd, srd; logic err; int w; bit done;
      xfer(0, 1'b1, 32'h0, 32'hFFFF, 0, rd, err, w, done, srd);
      tests++;
      if (err !== model_err(1'b1, 32'h0)) begin failed++; $display("FAIL err_wr_id got %b exp %b", err, model_err(1'b1, 32'h0)); end
      tests++;
      if (regs[0][31:0] !== ID) begin failed++; $display("FAIL err_id_kept got %h exp %h", regs[0][31:0], ID); end
      xfer(0, 1'b0, 32'h40, 32'h0, 0, rd, err, w, done, srd);
      tests++;
      if (err !== model_err(1'b0, 32'h40) || rd !== 32'h0) begin
         failed++; $display("FAIL err_rd_oor got %h/%b exp 0/%b", rd, err, model_err(1'b0, 32'h40));
      end
      xfer(0, 1'b1, 32'h40, 32'hCAFE, 0, rd, err, w, done, srd);
      tests++;
      if (regs[0] !== model_image(0)) begin failed++; $display("FAIL err_wr_oor_image got %h exp %h", regs[0], model_image(0)); end
   endtask

   task automatic test_abort();
      logic [31:0] rd, srd; logic err; int w; bit done;
      xfer(0, 1'b1, 32'h4, 32'h55, 1, rd, err, w, done, srd);
      @(negedge clk);
      tests++;
      if (pready[0] !== 1'b1) begin failed++; $display("FAIL abort_idle pready got %b exp 1", pready[0]); end
      tests++;
      if (regs[0][63:32] !== 32'h0) begin failed++; $display("FAIL abort_r1 got %h exp 0", regs[0][63:32]); end
      @(posedge clk); #1;
      xfer(0, 1'b0, 32'h4, 32'h0, 0, rd, err, w, done, srd);
      tests++;
      if (rd !== model_read(0, 32'h4) || w != 2) begin failed++; $display("FAIL abort_readback got %h waits %0d exp 0 waits 2", rd, w); end
   endtask

   task automatic test_idle_penable();
      psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 32'h4; pwdata[0] = 32'h77;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests++;
         if (pready[0] !== 1'b1) begin failed++; $display("FAIL idle_pen_pready cyc%0d got %b exp 1", i, pready[0]); end
         @(posedge clk); #1;
      end
      psel[0] = 1'b0; penable[0] = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (regs[0] !== model_image(0)) begin failed++; $display("FAIL idle_pen_image got %h exp %h", regs[0], model_image(0)); end
   endtask

   task automatic test_random(input int d);
      logic [31:0] rd, srd, addr, wd, exp_rd; logic err, exp_err; int w; bit done, wr;
      for (int n = 0; n < 30; n++) begin
         wr = 1'($urandom_range(0, 1));
         addr = 32'($urandom_range(0, 19)) << 2;
         if ($urandom_range(0, 9) == 0) addr = addr | 32'h8000_0000;
         wd = $urandom();
         exp_rd = wr ? 32'h0 : model_read(d, addr);
         exp_err = model_err(wr, addr);
         xfer(d, wr, addr, wd, 0, rd, err, w, done, srd);
         tests++;
         if (!done || rd !== exp_rd || err !== exp_err || w != wc(d) || srd !== 32'h0) begin
            failed++;
            $display("FAIL rand dut%0d n%0d a=%h wr=%b got rd=%h err=%b w=%0d srd=%h exp rd=%h err=%b w=%0d srd=0",
                     d, n, addr, wr, rd, err, w, srd, exp_rd, exp_err, wc(d));
         end
         if (done) model_commit(d, wr, addr, wd);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      tests++;
      if (regs[d] !== model_image(d)) begin failed++; $display("FAIL rand_image dut%0d got %h exp %h", d, regs[d], model_image(d)); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd, srd; logic err; int w; bit done;
      psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h10; pwdata[0] = 32'hA5A5A5A5;
      @(posedge clk); #1;
      penable[0] = 1'b1;
      @(negedge clk);
      tests++;
      if (pready[0] !== 1'b0) begin failed++; $display("FAIL midrst_wait pready got %b exp 0", pready[0]); end
      #2 prst_n[0] = 1'b0;
      for (int i = 0; i < NR; i++) mregs[0][i] = 32'h0;
      #1;
      tests++;
      if (pready[0] !== 1'b1 || pslverr[0] !== 1'b0 || prdata[0] !== 32'h0) begin
         failed++; $display("FAIL midrst_outputs got pready=%b pslverr=%b prdata=%h exp 1/0/0", pready[0], pslverr[0], prdata[0]);
      end
      tests++;
      if (regs[0] !== model_image(0)) begin failed++; $display("FAIL midrst_image got %h exp %h", regs[0], model_image(0)); end
      psel[0] = 1'b0; penable[0] = 1'b0;
      @(posedge clk); #1 prst_n[0] = 1'b1;
      @(posedge clk); #1;
      xfer(0, 1'b0, 32'h10, 32'h0, 0, rd, err, w, done, srd);
      tests++;
      if (rd !== 32'h0) begin failed++; $display("FAIL midrst_lost_write got %h exp 0", rd); end
      xfer(0, 1'b0, 32'h8, 32'h0, 0, rd, err, w, done, srd);
      tests++;
      if (rd !== model_read(0, 32'h8)) begin failed++; $display("FAIL midrst_cleared got %h exp %h", rd, model_read(0, 32'h8)); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < NR; i++) mregs[d][i] = 32'h0;
      test_reset();
      test_wait_states();
      test_zero_wait();
      test_errors();
      test_abort();
      test_idle_penable();
      test_random(0);
      test_random(1);
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
